// File: rtl/wb_sram_bridge.sv
// wb_sram_bridge
//   Wishbone slave that maps a 2 KB window (BASE_ADDR) onto a 1RW1R 32x512 SRAM macro.
//   Reads use SRAM port A, writes use port B. One transaction is in flight at a time and the
//   acknowledge is registered. Every SRAM-side output comes straight from a flop.
//   Optional feature: define SRAM_RD_CACHE_EN to add a one-entry read buffer that answers a
//   repeated read of the same word in one cycle without touching the SRAM.

module wb_sram_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned ADDR_W    = 9
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              sram_csb_a,
  output logic [ADDR_W-1:0] sram_addr_a,
  input  logic [31:0]       sram_dout_a,
  output logic              sram_csb_b,
  output logic              sram_web_b,
  output logic [3:0]        sram_mask_b,
  output logic [ADDR_W-1:0] sram_addr_b,
  output logic [31:0]       sram_din_b
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    ACK      = 3'd4
  } state_t;

  state_t state, state_d;

  logic              ack_d;
  logic [31:0]       dat_d;
  logic              csb_a_d;
  logic [ADDR_W-1:0] addr_a_d;
  logic              csb_b_d;
  logic              web_b_d;
  logic [3:0]        mask_b_d;
  logic [ADDR_W-1:0] addr_b_d;
  logic [31:0]       din_b_d;

  logic [ADDR_W-1:0] word_addr;
  logic              window_hit;
  logic              req;
  logic              unused_byte_offset;

  // Byte offset bits never select anything; the SRAM is word-addressed.
  assign word_addr          = wbs_adr_i[ADDR_W+1:2];
  assign window_hit         = (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign req                = wbs_stb_i & wbs_cyc_i & window_hit;
  assign unused_byte_offset = ^wbs_adr_i[1:0];

`ifdef SRAM_RD_CACHE_EN
  logic              cache_valid, cache_valid_d;
  logic [ADDR_W-1:0] cache_addr, cache_addr_d;
  logic [31:0]       cache_data, cache_data_d;
  logic              cache_hit;

  assign cache_hit = cache_valid && (cache_addr == word_addr);
`endif

  // Next-state and next-output logic; outputs fall back to their idle values each cycle.
  always_comb begin
    state_d  = state;
    ack_d    = 1'b0;
    dat_d    = '0;
    csb_a_d  = 1'b1;
    addr_a_d = sram_addr_a;
    csb_b_d  = 1'b1;
    web_b_d  = 1'b1;
    mask_b_d = sram_mask_b;
    addr_b_d = sram_addr_b;
    din_b_d  = sram_din_b;
`ifdef SRAM_RD_CACHE_EN
    cache_valid_d = cache_valid;
    cache_addr_d  = cache_addr;
    cache_data_d  = cache_data;
`endif

    case (state)
      IDLE: begin
        if (req) begin
          if (wbs_we_i) begin
            state_d  = WR;
            ack_d    = 1'b1;
            mask_b_d = wbs_sel_i;
            addr_b_d = word_addr;
            din_b_d  = wbs_dat_i;
            if (|wbs_sel_i) begin
              csb_b_d = 1'b0;
              web_b_d = 1'b0;
            end
`ifdef SRAM_RD_CACHE_EN
            if (cache_addr == word_addr) begin
              cache_valid_d = 1'b0;
            end
`endif
          end else begin
`ifdef SRAM_RD_CACHE_EN
            if (cache_hit) begin
              state_d = ACK;
              ack_d   = 1'b1;
              dat_d   = cache_data;
            end else begin
              state_d  = RD_ISSUE;
              csb_a_d  = 1'b0;
              addr_a_d = word_addr;
            end
`else
            state_d  = RD_ISSUE;
            csb_a_d  = 1'b0;
            addr_a_d = word_addr;
`endif
          end
        end
      end

      WR: begin
        state_d = IDLE;
      end

      RD_ISSUE: begin
        state_d = wbs_cyc_i ? RD_WAIT : IDLE;
      end

      RD_WAIT: begin
        if (wbs_cyc_i) begin
          state_d = ACK;
          ack_d   = 1'b1;
          dat_d   = sram_dout_a;
`ifdef SRAM_RD_CACHE_EN
          cache_valid_d = 1'b1;
          cache_addr_d  = sram_addr_a;
          cache_data_d  = sram_dout_a;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Bus and SRAM output registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
      sram_csb_a  <= 1'b1;
      sram_addr_a <= '0;
      sram_csb_b  <= 1'b1;
      sram_web_b  <= 1'b1;
      sram_mask_b <= '0;
      sram_addr_b <= '0;
      sram_din_b  <= '0;
    end else begin
      wbs_ack_o   <= ack_d;
      wbs_dat_o   <= dat_d;
      sram_csb_a  <= csb_a_d;
      sram_addr_a <= addr_a_d;
      sram_csb_b  <= csb_b_d;
      sram_web_b  <= web_b_d;
      sram_mask_b <= mask_b_d;
      sram_addr_b <= addr_b_d;
      sram_din_b  <= din_b_d;
    end
  end

`ifdef SRAM_RD_CACHE_EN
  // One-entry read buffer holding the last word read from the SRAM.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      cache_data  <= '0;
    end else begin
      cache_valid <= cache_valid_d;
      cache_addr  <= cache_addr_d;
      cache_data  <= cache_data_d;
    end
  end
`endif

endmodule

// File: tb/tb_wb_sram_bridge.sv
// tb_wb_sram_bridge
//   Bench for wb_sram_bridge. A transaction-level model (reference memory, latency table and an
//   optional read-buffer model under SRAM_RD_CACHE_EN) schedules what every output must look
//   like per cycle; one compare process checks the DUT against that schedule on every cycle.

module tb_wb_sram_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic [31:0] wbs_adr_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        sram_csb_a;
  logic [8:0]  sram_addr_a;
  logic [31:0] sram_dout_a;
  logic        sram_csb_b;
  logic        sram_web_b;
  logic [3:0]  sram_mask_b;
  logic [8:0]  sram_addr_b;
  logic [31:0] sram_din_b;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  logic chk_on = 1'b0;
  logic load_mem = 1'b0;

  logic [31:0] sram_mem [0:511];
  logic [31:0] ref_mem [0:511];
  logic        cvalid = 1'b0;
  logic [8:0]  caddr = 9'h0;

  typedef struct {
    logic        ack;
    logic        chk_dat;
    logic [31:0] dat;
    logic        csb_a;
    logic        chk_a;
    logic [8:0]  addr_a;
    logic        csb_b;
    logic        chk_web;
    logic        web_b;
    logic        chk_b;
    logic [3:0]  mask_b;
    logic [8:0]  addr_b;
    logic [31:0] din_b;
  } exp_t;

  exp_t sched [int];

  wb_sram_bridge #(.BASE_ADDR(BASE), .ADDR_W(9)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .sram_csb_a (sram_csb_a),
    .sram_addr_a(sram_addr_a),
    .sram_dout_a(sram_dout_a),
    .sram_csb_b (sram_csb_b),
    .sram_web_b (sram_web_b),
    .sram_mask_b(sram_mask_b),
    .sram_addr_b(sram_addr_b),
    .sram_din_b (sram_din_b)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Behavioural SRAM macro: synchronous read on port A, byte-masked write on port B.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 512; i++) sram_mem[i] <= ref_mem[i];
    end else begin
      if (!sram_csb_a) sram_dout_a <= sram_mem[sram_addr_a];
      if (!sram_csb_b && !sram_web_b) begin
        for (int b = 0; b < 4; b++)
          if (sram_mask_b[b]) sram_mem[sram_addr_b][8*b +: 8] <= sram_din_b[8*b +: 8];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc_cnt, act, expv);
    end
  endtask

  function automatic exp_t idleExp();
    exp_t e;
    e.ack = 1'b0;     e.chk_dat = 1'b1; e.dat = 32'h0;
    e.csb_a = 1'b1;   e.chk_a = 1'b0;   e.addr_a = 9'h0;
    e.csb_b = 1'b1;   e.chk_web = 1'b1; e.web_b = 1'b1;
    e.chk_b = 1'b0;   e.mask_b = 4'h0;  e.addr_b = 9'h0; e.din_b = 32'h0;
    return e;
  endfunction

  function automatic logic modelHit(input logic [8:0] w);
`ifdef SRAM_RD_CACHE_EN
    return cvalid && (caddr == w);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic inWindow(input logic [31:0] adr);
    return (adr >> 11) == (BASE >> 11);
  endfunction

  // Per-cycle compare of every DUT output against the scheduled expectation.
  always @(negedge clk) begin
    exp_t e;
    if (chk_on) begin
      if (sched.exists(cyc_cnt)) begin
        e = sched[cyc_cnt];
        sched.delete(cyc_cnt);
      end else begin
        e = idleExp();
      end
      checkOutput("ack", {31'h0, wbs_ack_o}, {31'h0, e.ack});
      if (e.chk_dat) checkOutput("dat_o", wbs_dat_o, e.dat);
      checkOutput("csb_a", {31'h0, sram_csb_a}, {31'h0, e.csb_a});
      if (e.chk_a) checkOutput("addr_a", {23'h0, sram_addr_a}, {23'h0, e.addr_a});
      checkOutput("csb_b", {31'h0, sram_csb_b}, {31'h0, e.csb_b});
      if (e.chk_web) checkOutput("web_b", {31'h0, sram_web_b}, {31'h0, e.web_b});
      if (e.chk_b) begin
        checkOutput("mask_b", {28'h0, sram_mask_b}, {28'h0, e.mask_b});
        checkOutput("addr_b", {23'h0, sram_addr_b}, {23'h0, e.addr_b});
        checkOutput("din_b", sram_din_b, e.din_b);
      end
    end
  end

  // Present one request (called just after a rising edge) and schedule its expected outputs.
  // lat is the ack latency in cycles, or -1 for an address outside the window.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                               input logic [31:0] dat, output int lat);
    int n;
    logic [8:0] w;
    exp_t e;
    n = cyc_cnt;
    w = adr[10:2];
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_sel_i = sel;  wbs_dat_i = dat;
    if (!inWindow(adr)) begin
      lat = -1;
    end else if (we) begin
      e = idleExp();
      e.ack = 1'b1; e.chk_dat = 1'b0;
      e.csb_b = (sel == 4'h0); e.chk_web = (sel != 4'h0); e.web_b = 1'b0;
      e.chk_b = (sel != 4'h0); e.mask_b = sel; e.addr_b = w; e.din_b = dat;
      sched[n + 1] = e;
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[w][8*b +: 8] = dat[8*b +: 8];
      if (caddr == w) cvalid = 1'b0;
      lat = 1;
    end else if (modelHit(w)) begin
      e = idleExp();
      e.ack = 1'b1; e.dat = ref_mem[w];
      sched[n + 1] = e;
      lat = 1;
    end else begin
      e = idleExp();
      e.csb_a = 1'b0; e.chk_a = 1'b1; e.addr_a = w;
      sched[n + 1] = e;
      e = idleExp();
      e.ack = 1'b1; e.dat = ref_mem[w];
      sched[n + 3] = e;
      cvalid = 1'b1; caddr = w;
      lat = 3;
    end
  endtask

  // Run a full transaction; the request stays up through the ack cycle, as a real master does.
  task automatic doTxn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, output logic [31:0] dat_seen, output int lat);
    applyStimulus(we, adr, sel, dat, lat);
    dat_seen = 32'h0;
    if (lat < 0) begin
      repeat (8) @(posedge clk);
      #1;
    end else begin
      repeat (lat + 1) @(negedge clk);
      dat_seen = wbs_dat_o;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idleBus(input int k);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Read that the master abandons in RD_ISSUE (stage 1) or RD_WAIT (stage 2).
  task automatic readAbort(input logic [31:0] adr, input int stage);
    exp_t e;
    logic [31:0] d;
    int lat;
    if (!inWindow(adr) || modelHit(adr[10:2])) begin
      doTxn(1'b0, adr, 4'hF, 32'h0, d, lat);
    end else begin
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = adr;
      e = idleExp();
      e.csb_a = 1'b0; e.chk_a = 1'b1; e.addr_a = adr[10:2];
      sched[cyc_cnt + 1] = e;
      repeat (stage) @(posedge clk);
      #1;
      idleBus(1);
    end
  endtask

  logic [31:0] dseen;
  int          lat;

  initial begin
    #1 rst_n = 1'b0;
    for (int i = 0; i < 512; i++) ref_mem[i] = $urandom;
    load_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1 load_mem = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] idle bus after reset");
    idleBus(10);

    $display("[TB] full write then read back");
    doTxn(1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, dseen, lat);
    checkOutput("t2_wr_lat", lat, 1);
    doTxn(1'b0, 32'h3000_0010, 4'hF, 32'h0, dseen, lat);
    checkOutput("t2_rd_lat", lat, 3);
    checkOutput("t2_rd_data", dseen, 32'hDEAD_BEEF);

    $display("[TB] partial and empty byte selects");
    doTxn(1'b1, 32'h3000_001C, 4'hF, 32'hFFFF_FFFF, dseen, lat);
    doTxn(1'b1, 32'h3000_001C, 4'b0011, 32'h1234_5678, dseen, lat);
    doTxn(1'b0, 32'h3000_001C, 4'hF, 32'h0, dseen, lat);
    checkOutput("t3_partial", dseen, 32'hFFFF_5678);
    applyStimulus(1'b1, 32'h3000_001C, 4'b0000, 32'hAAAA_AAAA, lat);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t3_sel0_ack", {31'h0, wbs_ack_o}, 32'h1);
    checkOutput("t3_sel0_csb_b", {31'h0, sram_csb_b}, 32'h1);
    @(posedge clk);
    #1;
    doTxn(1'b0, 32'h3000_001C, 4'hF, 32'h0, dseen, lat);
    checkOutput("t3_sel0_keep", dseen, 32'hFFFF_5678);

    $display("[TB] window boundaries");
    doTxn(1'b1, 32'h3000_0800, 4'hF, 32'h5555_5555, dseen, lat);
    checkOutput("t4_miss_lat", lat, -1);
    idleBus(1);
    doTxn(1'b1, 32'h3000_07FC, 4'hF, 32'hA5A5_0511, dseen, lat);
    doTxn(1'b0, 32'h3000_07FE, 4'hF, 32'h0, dseen, lat);
    checkOutput("t4_word511", dseen, 32'hA5A5_0511);

    $display("[TB] reset in the middle of a read");
    doTxn(1'b1, 32'h3000_0050, 4'hF, 32'h0BAD_F00D, dseen, lat);
    applyStimulus(1'b0, 32'h3000_0050, 4'hF, 32'h0, lat);
    repeat (2) @(posedge clk);
    #1;
    sched.delete();
    cvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_csb_a", {31'h0, sram_csb_a}, 32'h1);
    checkOutput("t5_ack", {31'h0, wbs_ack_o}, 32'h0);
    checkOutput("t5_dat_o", wbs_dat_o, 32'h0);
    checkOutput("t5_addr_a", {23'h0, sram_addr_a}, 32'h0);
    checkOutput("t5_csb_b", {31'h0, sram_csb_b}, 32'h1);
    checkOutput("t5_web_b", {31'h0, sram_web_b}, 32'h1);
    checkOutput("t5_mask_b", {28'h0, sram_mask_b}, 32'h0);
    checkOutput("t5_addr_b", {23'h0, sram_addr_b}, 32'h0);
    checkOutput("t5_din_b", sram_din_b, 32'h0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    doTxn(1'b0, 32'h3000_0050, 4'hF, 32'h0, dseen, lat);
    checkOutput("t5_after_reset", dseen, 32'h0BAD_F00D);

    $display("[TB] master abort");
    readAbort(32'h3000_0040, 1);
    readAbort(32'h3000_0044, 2);

`ifdef SRAM_RD_CACHE_EN
    $display("[TB] read buffer");
    doTxn(1'b0, 32'h3000_000C, 4'hF, 32'h0, dseen, lat);
    checkOutput("t6_first_lat", lat, 3);
    doTxn(1'b0, 32'h3000_000C, 4'hF, 32'h0, dseen, lat);
    checkOutput("t6_hit_lat", lat, 1);
    doTxn(1'b1, 32'h3000_000C, 4'hF, 32'hC0DE_0003, dseen, lat);
    doTxn(1'b0, 32'h3000_000C, 4'hF, 32'h0, dseen, lat);
    checkOutput("t6_after_wr_lat", lat, 3);
    checkOutput("t6_after_wr_data", dseen, 32'hC0DE_0003);
`endif

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      int kind;
      int r;
      logic [8:0] w;
      logic [31:0] adr;
      kind = $urandom_range(0, 9);
      r = $urandom_range(0, 7);
      if (r == 0) w = 9'd511;
      else if (r == 1) w = 9'($urandom_range(0, 511));
      else w = 9'($urandom_range(0, 7));
      adr = BASE | {21'h0, w, 2'b00} | 32'($urandom_range(0, 3));
      if (kind == 0) begin
        adr = $urandom;
        if (inWindow(adr)) adr = adr ^ 32'h8000_0000;
        doTxn(1'($urandom_range(0, 1)), adr, 4'($urandom_range(0, 15)), $urandom, dseen, lat);
      end else if (kind == 1) begin
        readAbort(adr, $urandom_range(1, 2));
      end else begin
        doTxn(1'($urandom_range(0, 1)), adr, 4'($urandom_range(0, 15)), $urandom, dseen, lat);
      end
      r = $urandom_range(0, 2);
      if (r != 0) idleBus(r);
    end

    idleBus(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
